// File: rtl/key_filter_pkg.sv
// Shared constants and counter sizing helper for the key filter bank.
package key_filter_pkg;

   localparam int CNT_MAX_20MS_50M = 999_999;
   localparam int LONG_CNT_1S_50M  = 49_999_999;

   localparam int LED_FOLLOW = 0;
   localparam int LED_TOGGLE = 1;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: synchroniser, debounce counter, edge pulses, LED drive.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_filter_ch
   import key_filter_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_MAX     = CNT_MAX_20MS_50M,
`ifdef KEY_LONG_PRESS_EN
   parameter int LONG_CNT    = LONG_CNT_1S_50M,
`endif
   parameter int LED_MODE    = LED_FOLLOW
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic level,
   output logic press,
   output logic rel,
   output logic led,
   output logic long_press
);

   localparam int CNT_W = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync;
   logic                   stable;
   logic [CNT_W-1:0]       cnt;
   logic                   done;
   logic                   level_nxt;
   logic                   long_hit;

   assign sync      = sync_ff[SYNC_STAGES-1];
   assign done      = (sync != stable) && (cnt == CNT_TOP);
   assign level_nxt = done ? ~sync : level;

   // stable keeps raw polarity (1 = released); level is its registered inverse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '1;
         stable  <= 1'b1;
         cnt     <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
         rel     <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], key};
         level   <= level_nxt;
         press   <= done & ~sync;
         rel     <= done & sync;
         if (sync == stable)
            cnt <= '0;
         else if (done) begin
            cnt    <= '0;
            stable <= sync;
         end else
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         led <= 1'b0;
      else if (LED_MODE == LED_TOGGLE) begin
         if (long_hit)
            led <= 1'b0;
         else if (done & ~sync)
            led <= ~led;
      end else
         led <= level_nxt;
   end

`ifdef KEY_LONG_PRESS_EN
   localparam int LONG_W = cnt_width(LONG_CNT);
   localparam logic [LONG_W-1:0] LONG_TOP = LONG_W'(LONG_CNT);
   localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CNT - 1);

   logic [LONG_W-1:0] lcnt;

   // Fires on the edge the counter steps onto LONG_CNT; saturation blocks repeats.
   assign long_hit = level && (lcnt == LONG_PRE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= long_hit;
         if (!level)
            lcnt <= '0;
         else if (lcnt != LONG_TOP)
            lcnt <= lcnt + 1'b1;
      end
   end
`else
   assign long_hit   = 1'b0;
   assign long_press = 1'b0;
`endif

endmodule

// File: rtl/key_filter_bank.sv
// N-channel debounced key conditioner; active-low raw keys in, active-high outputs.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_filter_bank
   import key_filter_pkg::*;
#(
   parameter int CH_NUM      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_MAX     = CNT_MAX_20MS_50M,
`ifdef KEY_LONG_PRESS_EN
   parameter int LONG_CNT    = LONG_CNT_1S_50M,
`endif
   parameter int LED_MODE    = LED_FOLLOW
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [CH_NUM-1:0] key_in,
   output logic [CH_NUM-1:0] key_level,
   output logic [CH_NUM-1:0] key_press,
   output logic [CH_NUM-1:0] key_release,
   output logic [CH_NUM-1:0] led_out,
   output logic [CH_NUM-1:0] key_long
);

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      key_filter_ch #(
         .SYNC_STAGES (SYNC_STAGES),
         .CNT_MAX     (CNT_MAX),
`ifdef KEY_LONG_PRESS_EN
         .LONG_CNT    (LONG_CNT),
`endif
         .LED_MODE    (LED_MODE)
      ) u_ch (
         .clk        (sys_clk),
         .rst_n      (sys_rst_n),
         .key        (key_in[i]),
         .level      (key_level[i]),
         .press      (key_press[i]),
         .rel        (key_release[i]),
         .led        (led_out[i]),
         .long_press (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_filter_bank.sv
// Directed bench: one follow-mode and one toggle-mode bank share keys and reset.
module tb_key_filter_bank;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [3:0] key_in;
   logic [3:0] lv_f, pr_f, rl_f, led_f, lg_f;
   logic [3:0] lv_t, pr_t, rl_t, led_t, lg_t;
   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   key_filter_bank #(
      .CH_NUM(4), .SYNC_STAGES(2), .CNT_MAX(7),
`ifdef KEY_LONG_PRESS_EN
      .LONG_CNT(20),
`endif
      .LED_MODE(0)
   ) u_follow (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
      .key_level(lv_f), .key_press(pr_f), .key_release(rl_f),
      .led_out(led_f), .key_long(lg_f)
   );

   key_filter_bank #(
      .CH_NUM(4), .SYNC_STAGES(2), .CNT_MAX(7),
`ifdef KEY_LONG_PRESS_EN
      .LONG_CNT(20),
`endif
      .LED_MODE(1)
   ) u_toggle (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_in(key_in),
      .key_level(lv_t), .key_press(pr_t), .key_release(rl_t),
      .led_out(led_t), .key_long(lg_t)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      key_in    = 4'hf;
      sys_rst_n = 1'b0;
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [39:0] all_out;
      sys_rst_n = 1'b0;
      key_in    = 4'h0;
      for (int i = 0; i < 5; i++) begin
         tick();
         all_out = {lv_f, pr_f, rl_f, led_f, lg_f, lv_t, pr_t, rl_t, led_t, lg_t};
         checks++;
         if (all_out !== 40'h0) begin
            errors++;
            $display("FAIL reset_hold cyc%0d: got %h want 0", i, all_out);
         end
      end
      sys_rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (k < 9) begin
            if ((pr_f | pr_t | lv_f) !== 4'h0) begin
               errors++;
               $display("FAIL reset_early_press k%0d: press %b level %b want 0", k, pr_f, lv_f);
            end
         end else if (pr_f !== 4'hf || lv_f !== 4'hf || led_f !== 4'hf || led_t !== 4'hf) begin
            errors++;
            $display("FAIL reset_requal: press %b level %b ledf %b ledt %b want 1111", pr_f, lv_f, led_f, led_t);
         end
      end
      key_in = 4'hf;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (k < 9) begin
            if (rl_f !== 4'h0 || lv_f !== 4'hf) begin
               errors++;
               $display("FAIL release_early k%0d: release %b level %b", k, rl_f, lv_f);
            end
         end else if (rl_f !== 4'hf || lv_f !== 4'h0 || led_f !== 4'h0 || led_t !== 4'hf) begin
            errors++;
            $display("FAIL release_all: release %b level %b ledf %b ledt %b", rl_f, lv_f, led_f, led_t);
         end
      end
   endtask

   task automatic test_clean_press();
      logic exp_lv;
      do_reset();
      key_in[0] = 1'b0;
      for (int k = 0; k < 11; k++) begin
         tick();
         exp_lv = (k >= 9);
         checks++;
         if (lv_f[0] !== exp_lv || pr_f[0] !== (k == 9) || led_f[0] !== exp_lv ||
             led_t[0] !== exp_lv || {pr_f[3:1], rl_f} !== 7'h0) begin
            errors++;
            $display("FAIL clean_press k%0d: level %b press %b ledf %b ledt %b rel %b",
                     k, lv_f, pr_f, led_f, led_t, rl_f);
         end
      end
      key_in[0] = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         exp_lv = (k < 9);
         checks++;
         if (lv_f[0] !== exp_lv || rl_f[0] !== (k == 9) || led_f[0] !== exp_lv ||
             led_t[0] !== 1'b1 || pr_f !== 4'h0) begin
            errors++;
            $display("FAIL clean_release k%0d: level %b rel %b ledf %b ledt %b press %b",
                     k, lv_f, rl_f, led_f, led_t, pr_f);
         end
      end
   endtask

   task automatic test_bounce();
      int n_pulse = 0;
      int n_press = 0;
      int at_k = -1;
      do_reset();
      for (int s = 0; s < 3; s++) begin
         key_in[1] = (s % 2 == 0);
         for (int c = 0; c < 3; c++) begin
            tick();
            n_pulse += int'(pr_f[1]) + int'(rl_f[1]);
         end
      end
      checks++;
      if (n_pulse != 0) begin
         errors++;
         $display("FAIL bounce_quiet: got %0d pulses want 0", n_pulse);
      end
      key_in[1] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (pr_f[1]) begin
            n_press++;
            at_k = k;
         end
      end
      checks++;
      if (n_press != 1 || at_k != 9 || lv_f[1] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_press: got %0d presses at k%0d level %b want 1 at k9",
                  n_press, at_k, lv_f[1]);
      end
   endtask

   task automatic test_toggle();
      logic exp_led = 1'b0;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         key_in[2] = 1'b0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 8) begin
               checks++;
               if (led_t[2] !== exp_led || pr_t[2] !== 1'b0) begin
                  errors++;
                  $display("FAIL toggle_pre p%0d: led %b press %b want led %b", p, led_t[2], pr_t[2], exp_led);
               end
            end else if (k == 9) begin
               exp_led = ~exp_led;
               checks++;
               if (led_t[2] !== exp_led || pr_t[2] !== 1'b1 || led_f[2] !== 1'b1) begin
                  errors++;
                  $display("FAIL toggle_press p%0d: led %b press %b ledf %b want led %b",
                           p, led_t[2], pr_t[2], led_f[2], exp_led);
               end
            end
         end
         key_in[2] = 1'b1;
         for (int k = 0; k < 12; k++) tick();
         checks++;
         if (led_t[2] !== exp_led || led_f[2] !== 1'b0) begin
            errors++;
            $display("FAIL toggle_release p%0d: led %b ledf %b want led %b", p, led_t[2], led_f[2], exp_led);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [39:0] all_out;
      do_reset();
      key_in[0] = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      key_in[3] = 1'b0;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (lv_f[0] !== 1'b1 || led_t[0] !== 1'b1 || lv_f[3] !== 1'b0) begin
         errors++;
         $display("FAIL async_pre: level %b ledt %b want level 0001 ledt[0]=1", lv_f, led_t);
      end
      #3;
      sys_rst_n = 1'b0;
      #1;
      all_out = {lv_f, pr_f, rl_f, led_f, lg_f, lv_t, pr_t, rl_t, led_t, lg_t};
      checks++;
      if (all_out !== 40'h0) begin
         errors++;
         $display("FAIL async_clear: got %h want 0", all_out);
      end
      tick();
      all_out = {lv_f, pr_f, rl_f, led_f, lg_f, lv_t, pr_t, rl_t, led_t, lg_t};
      checks++;
      if (all_out !== 40'h0) begin
         errors++;
         $display("FAIL async_hold: got %h want 0", all_out);
      end
      sys_rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (k < 9) begin
            if ((pr_f | lv_f | rl_f) !== 4'h0) begin
               errors++;
               $display("FAIL async_early k%0d: press %b level %b rel %b want 0", k, pr_f, lv_f, rl_f);
            end
         end else if (pr_f !== 4'b1001 || lv_f !== 4'b1001) begin
            errors++;
            $display("FAIL async_requal: press %b level %b want 1001", pr_f, lv_f);
         end
      end
   endtask

   task automatic test_long();
      do_reset();
      key_in[0] = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++;
      if (pr_t[0] !== 1'b1 || led_t[0] !== 1'b1) begin
         errors++;
         $display("FAIL long_press_start: press %b led %b want 1 1", pr_t[0], led_t[0]);
      end
      for (int j = 1; j <= 40; j++) begin
         tick();
         checks++;
`ifdef KEY_LONG_PRESS_EN
         if (lg_t[0] !== (j == 20) || lg_f[0] !== (j == 20) || led_t[0] !== (j < 20) ||
             led_f[0] !== 1'b1 || lg_t[3:1] !== 3'h0) begin
            errors++;
            $display("FAIL long_pulse j%0d: longt %b longf %b ledt %b ledf %b", j, lg_t, lg_f, led_t, led_f);
         end
`else
         if ((lg_t | lg_f) !== 4'h0 || led_t[0] !== 1'b1) begin
            errors++;
            $display("FAIL long_off j%0d: longt %b longf %b ledt %b want 0 0 1", j, lg_t, lg_f, led_t[0]);
         end
`endif
      end
      key_in[0] = 1'b1;
      for (int k = 0; k < 12; k++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      sys_rst_n = 1'b0;
      key_in    = 4'hf;
      test_reset();
      test_clean_press();
      test_bounce();
      test_toggle();
      test_async_reset();
      test_long();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
